// File: rtl/note_detector.sv
// Note detector: measures tone_in period and locks onto one of five notes (C..G).
// Optional NOTEDET_GLITCH_FILTER_EN adds a 3-sample majority filter after the synchronizer.
module note_detector #(
  parameter int unsigned TOL_SHIFT  = 6,
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned N_C        = 382219,
  parameter int unsigned N_D        = 340530,
  parameter int unsigned N_E        = 303370,
  parameter int unsigned N_F        = 286344,
  parameter int unsigned N_G        = 255102,
  parameter int unsigned TIMEOUT    = 1048575
) (
  input  logic clk,
  input  logic reset,
  input  logic tone_in,
  output logic noteC,
  output logic noteD,
  output logic noteE,
  output logic noteF,
  output logic noteG,
  output logic tone_present,
  output logic note_change
);

  localparam int unsigned CW = 20;
  localparam int unsigned MW = 3;

  localparam logic [2:0] NOTE_NONE = 3'd0;
  localparam logic [2:0] NOTE_C    = 3'd1;
  localparam logic [2:0] NOTE_D    = 3'd2;
  localparam logic [2:0] NOTE_E    = 3'd3;
  localparam logic [2:0] NOTE_F    = 3'd4;
  localparam logic [2:0] NOTE_G    = 3'd5;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            tone_s, tone_f, prev_q, rise_c;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_c;
  logic [2:0]      cand_c, cand_q, cand_d, note_q, note_d;
  logic [MW-1:0]   match_q, match_d;
  logic [4:0]      flags_q, flags_d;
  logic            present_q, change_q;

  assign tone_s = sync_q[1];

`ifdef NOTEDET_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q, maj_c;
  assign maj_c  = (tone_s & hist_q[0]) | (tone_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
  assign tone_f = filt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= 2'b00;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], tone_s};
      filt_q <= maj_c;
    end
  end
`else
  assign tone_f = tone_s;
`endif

  assign rise_c    = tone_f & ~prev_q;
  // An edge in the same cycle as saturation wins over the timeout.
  assign timeout_c = (cnt_q == CW'(TIMEOUT)) && !rise_c;

  always_comb begin
    cnt_d = cnt_q;
    if (rise_c)                     cnt_d = CW'(1);
    else if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + CW'(1);
  end

  function automatic logic in_win(input logic [CW-1:0] p, input int unsigned nom);
    logic [CW-1:0] n, d;
    n = CW'(nom);
    d = (p >= n) ? (p - n) : (n - p);
    return d <= CW'(nom >> TOL_SHIFT);
  endfunction

  // Windows are disjoint, so the codes can simply be OR-ed together.
  always_comb begin
    cand_c = NOTE_NONE;
    cand_c = cand_c | ({3{in_win(cnt_q, N_C)}} & NOTE_C);
    cand_c = cand_c | ({3{in_win(cnt_q, N_D)}} & NOTE_D);
    cand_c = cand_c | ({3{in_win(cnt_q, N_E)}} & NOTE_E);
    cand_c = cand_c | ({3{in_win(cnt_q, N_F)}} & NOTE_F);
    cand_c = cand_c | ({3{in_win(cnt_q, N_G)}} & NOTE_G);
  end

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    cand_d  = cand_q;
    match_d = match_q;
    if (timeout_c) begin
      state_d = IDLE;
      note_d  = NOTE_NONE;
      cand_d  = NOTE_NONE;
      match_d = '0;
    end else if (rise_c) begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM, MEASURE: begin
          state_d = MEASURE;
          cand_d  = cand_c;
          if (cand_c == NOTE_NONE)                      match_d = '0;
          else if (cand_c == cand_q && match_q != '0)   match_d = match_q + MW'(1);
          else                                          match_d = MW'(1);
          if (match_d == MW'(STABLE_CNT)) begin
            state_d = LOCKED;
            note_d  = cand_c;
            cand_d  = NOTE_NONE;
            match_d = '0;
          end
        end
        LOCKED: begin
          // Count consecutive periods that disagree with the locked note ("none" included).
          if (cand_c == note_q) begin
            cand_d  = NOTE_NONE;
            match_d = '0;
          end else begin
            cand_d  = cand_c;
            if (cand_c == cand_q && match_q != '0) match_d = match_q + MW'(1);
            else                                   match_d = MW'(1);
            if (match_d == MW'(STABLE_CNT)) begin
              if (cand_c == NOTE_NONE) state_d = MEASURE;
              note_d  = cand_c;
              cand_d  = NOTE_NONE;
              match_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    flags_d = 5'b00000;
    case (note_d)
      NOTE_C:  flags_d = 5'b00001;
      NOTE_D:  flags_d = 5'b00010;
      NOTE_E:  flags_d = 5'b00100;
      NOTE_F:  flags_d = 5'b01000;
      NOTE_G:  flags_d = 5'b10000;
      default: flags_d = 5'b00000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b00;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      state_q   <= IDLE;
      cand_q    <= NOTE_NONE;
      note_q    <= NOTE_NONE;
      match_q   <= '0;
      flags_q   <= 5'b00000;
      present_q <= 1'b0;
      change_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], tone_in};
      prev_q    <= tone_f;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      cand_q    <= cand_d;
      note_q    <= note_d;
      match_q   <= match_d;
      flags_q   <= flags_d;
      present_q <= (note_d != NOTE_NONE);
      change_q  <= (note_d != note_q);
    end
  end

  assign noteC        = flags_q[0];
  assign noteD        = flags_q[1];
  assign noteE        = flags_q[2];
  assign noteF        = flags_q[3];
  assign noteG        = flags_q[4];
  assign tone_present = present_q;
  assign note_change  = change_q;

endmodule

// File: doc/note_detector.md
NOTE_DETECTOR -- requirements
Module: note_detector

Interface
REQ-001 Parameter TOL_SHIFT, default 6: period tolerance is nominal >> TOL_SHIFT (about 1.6%).
REQ-002 Parameter STABLE_CNT, default 4: consecutive same-note periods required to lock.
REQ-003 Port clk, input, 1: system clock, 100 MHz, rising edge; the single clock of the block.
REQ-004 Port reset, input, 1: asynchronous active-high reset.
REQ-005 Port tone_in, input, 1: asynchronous square-wave tone input (the speaker-line signal).
REQ-006 Port noteC, noteD, noteE, noteF, noteG, output, 1 each: one-hot locked-note flags.
REQ-007 Port tone_present, output, 1: high while any note is locked.
REQ-008 Port note_change, output, 1: one-cycle pulse when the locked note changes, including to or from no note.

Function
REQ-009 tone_in SHALL pass through a 2-flop synchronizer; rising edges are detected on the synchronized signal.
REQ-010 A 20-bit period counter SHALL count clk cycles between consecutive synchronized rising edges.
REQ-011 On each rising edge the counter value P SHALL be captured and the counter SHALL restart at 1.
REQ-012 Nominal periods in cycles SHALL be C=382219, D=340530, E=303370, F=286344, G=255102.
REQ-013 P SHALL classify as note X when |P - N_X| <= (N_X >> TOL_SHIFT); otherwise P is "none".
REQ-014 The tolerance windows SHALL NOT overlap at the default TOL_SHIFT; no priority logic is needed.
REQ-015 FSM states SHALL be IDLE, ARM, MEASURE and LOCKED.
REQ-016 IDLE -> ARM on the first rising edge; that first edge produces no P.
REQ-017 ARM -> MEASURE on the next edge, producing the first valid P.
REQ-018 In MEASURE, a 3-bit match counter SHALL increment while the candidate note repeats and SHALL reload to 1 when the candidate changes.
REQ-019 A "none" candidate in MEASURE SHALL clear the match counter to 0.
REQ-020 When the match count reaches STABLE_CNT, the FSM SHALL enter LOCKED and outputs SHALL update on the following cycle.
REQ-021 In LOCKED, STABLE_CNT consecutive periods of a different valid note SHALL switch the lock directly to that note.
REQ-022 In LOCKED, STABLE_CNT consecutive "none" periods SHALL drop the lock and return to MEASURE.
REQ-023 Fewer than STABLE_CNT deviating periods SHALL leave the lock unchanged.
REQ-024 If the period counter reaches 1048575 with no edge, it SHALL saturate, the FSM SHALL enter IDLE, and all note outputs SHALL clear.
REQ-025 note_change SHALL pulse in the same cycle the note outputs change; it SHALL never pulse twice without an output change between.
REQ-026 When a timeout coincides with a rising edge in the same cycle, the edge SHALL win: no timeout occurs.
REQ-027 At most one of noteC..noteG SHALL be high in any cycle; tone_present SHALL equal the OR of the five flags.

Reset
REQ-028 Reset SHALL put the FSM in IDLE and clear the counters, the synchronizer and all outputs to 0.
REQ-029 Reset asserted mid-measurement SHALL discard any partial period; note_change SHALL NOT pulse on reset release.

Configuration
REQ-030 Macro NOTEDET_GLITCH_FILTER_EN:
- When defined: a 3-sample majority filter follows the synchronizer and adds 2 cycles of edge latency; single-cycle glitches are rejected.
- When undefined: no filter; the synchronized signal feeds edge detection directly.

Verification
REQ-031 Scenario 1: 262 Hz square wave (period 382219 cycles) for 6 periods -> noteC=1 after the 5th edge plus 1 cycle, note_change pulses once, tone_present=1.
REQ-032 Scenario 2: Lock on E (period 303370), then switch to G (period 255102) -> noteE holds through 3 G periods; noteG=1 after the 4th G period with a single note_change pulse.
REQ-033 Scenario 3: Lock on D, then hold tone_in low -> outputs clear after 1048575 idle cycles with a note_change pulse; FSM in IDLE.
REQ-034 Scenario 4: Period 320000 (between D and E) -> no note output ever asserts.
REQ-035 Scenario 5: Assert reset during the 3rd C period -> all outputs 0; after release, lock requires a fresh ARM and 4 periods.
REQ-036 Scenario 6 (NOTEDET_GLITCH_FILTER_EN defined): 1-cycle high glitches injected mid-period on a locked F tone -> lock is retained and no note_change pulse occurs.
